// File: rtl/ovs_pkg.sv
// Shared definitions for the rx-to-tx frame merging path.
package ovs_pkg;

  localparam int unsigned FIFO_W = 9;
  localparam int unsigned DV_BIT = 8;
  localparam logic [FIFO_W-1:0] END_WORD = 9'h000;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN
  } state_t;

  // One-hot grant vector for a port index.
  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on contention the port that did not go last wins.
module rr_pick2
  import ovs_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);

  // Decode the request pair into a one-hot winner.
  always_comb begin
    pick_o = 2'b00;
    unique case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = onehot2(!last_i);
      default: pick_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/frame_arbiter.sv
// Frame-granular 2:1 round-robin merge of two rx read FIFOs into one tx write FIFO.
// Frames are never interleaved; overlong frames are cut at MAX_LEN and closed
// with END_WORD, and the rest of the frame is drained from the source.
module frame_arbiter
  import ovs_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1536,
  parameter int unsigned LEN_W   = 11,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic [1:0]        port_en,
  output logic              rd0_en,
  input  logic [8:0]        rd0_data,
  input  logic              rd0_empty,
  output logic              rd1_en,
  input  logic [8:0]        rd1_data,
  input  logic              rd1_empty,
  output logic              wr_en,
  output logic [8:0]        wr_data,
  input  logic              wr_full,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  frame_cnt0,
  output logic [CNT_W-1:0]  frame_cnt1,
  output logic [CNT_W-1:0]  trunc_cnt
);

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  state_t              state_q;
  logic                owner_q;     // port index of the current frame
  logic                last_q;      // port that completed the previous frame
  logic                rd_vld_q;    // a word requested last cycle is on rdN_data
  logic [LEN_W-1:0]    byte_cnt_q;

  logic [FIFO_W-1:0]   rd_word;
  logic                end_seen;
  logic                reading;
  logic [1:0]          req;
  logic [1:0]          pick;

  rr_pick2 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .pick_o (pick)
  );

  // Read strobes and arbitration requests; end_seen blocks a read past the end marker.
  always_comb begin
    rd_word  = owner_q ? rd1_data : rd0_data;
    end_seen = rd_vld_q && !rd_word[DV_BIT];
    reading  = (state_q == SEND || state_q == DRAIN) && !wr_full && !end_seen;
    rd0_en   = reading && !owner_q && !rd0_empty;
    rd1_en   = reading &&  owner_q && !rd1_empty;
    req      = port_en & {!rd1_empty, !rd0_empty};
  end

  // Frame FSM with registered write port, grant and statistics.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      rd_vld_q   <= 1'b0;
      byte_cnt_q <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      grant      <= 2'b00;
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
      trunc_cnt  <= '0;
    end else begin
      rd_vld_q <= rd0_en | rd1_en;
      wr_en    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick != 2'b00) begin
            state_q    <= SEND;
            grant      <= pick;
            owner_q    <= pick[1];
            byte_cnt_q <= '0;
          end
        end
        SEND: begin
          if (rd_vld_q) begin
            if (rd_word[DV_BIT]) begin
              if (byte_cnt_q < MAX_CNT) begin
                wr_en      <= 1'b1;
                wr_data    <= rd_word;
                byte_cnt_q <= byte_cnt_q + 1'b1;
              end else begin
                // Overlong: close the frame here and discard the remainder.
                wr_en     <= 1'b1;
                wr_data   <= END_WORD;
                trunc_cnt <= trunc_cnt + 1'b1;
                if (owner_q) frame_cnt1 <= frame_cnt1 + 1'b1;
                else         frame_cnt0 <= frame_cnt0 + 1'b1;
                last_q    <= owner_q;
                state_q   <= DRAIN;
              end
            end else if (byte_cnt_q != '0) begin
              wr_en   <= 1'b1;
              wr_data <= rd_word;
              if (owner_q) frame_cnt1 <= frame_cnt1 + 1'b1;
              else         frame_cnt0 <= frame_cnt0 + 1'b1;
              last_q  <= owner_q;
              grant   <= 2'b00;
              state_q <= IDLE;
            end else begin
              // Stray gap word with no payload: drop silently.
              grant   <= 2'b00;
              state_q <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (end_seen) begin
            grant   <= 2'b00;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_arbiter.sv
// Randomized scoreboard bench for frame_arbiter with a frame-level reference model.
module tb_frame_arbiter;

  localparam int unsigned MAXL = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rstn = 1'b0;
  logic [1:0]  port_en = 2'b00;
  logic        rd0_en, rd1_en;
  logic [8:0]  rd0_data = '0;
  logic [8:0]  rd1_data = '0;
  logic        rd0_empty = 1'b1;
  logic        rd1_empty = 1'b1;
  logic        wr_en;
  logic [8:0]  wr_data;
  logic        wr_full = 1'b0;
  logic [1:0]  grant;
  logic [15:0] frame_cnt0, frame_cnt1, trunc_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // DUT-side FIFO contents, model-side frame store, expected output stream
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] mw0[$];
  logic [8:0] mw1[$];
  int         ml0[$];
  int         ml1[$];
  logic [8:0] stage_q[$];
  logic [8:0] exp_q[$];
  int         exp_fc0 = 0;
  int         exp_fc1 = 0;
  int         exp_tc = 0;
  logic       m_last = 1'b1;

  int full_mode = 0;  // 0 off, 1 random, 2 forced on
  int hold = 0;
  int full_wr = 0;

  frame_arbiter #(
    .MAX_LEN (MAXL),
    .LEN_W   (4),
    .CNT_W   (16)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rstn   (sys_rstn),
    .port_en    (port_en),
    .rd0_en     (rd0_en),
    .rd0_data   (rd0_data),
    .rd0_empty  (rd0_empty),
    .rd1_en     (rd1_en),
    .rd1_data   (rd1_data),
    .rd1_empty  (rd1_empty),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_full    (wr_full),
    .grant      (grant),
    .frame_cnt0 (frame_cnt0),
    .frame_cnt1 (frame_cnt1),
    .trunc_cnt  (trunc_cnt)
  );

  initial forever #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source FIFOs: word appears the cycle after the read strobe
  always @(posedge sys_clk) begin
    if (rd0_en) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL rd0_underflow: got read expected no read");
      end else rd0_data <= q0.pop_front();
    end
    if (rd1_en) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL rd1_underflow: got read expected no read");
      end else rd1_data <= q1.pop_front();
    end
    rd0_empty <= (q0.size() == 0);
    rd1_empty <= (q1.size() == 0);
  end

  // Output almost-full driver
  initial forever begin
    @(posedge sys_clk);
    #1;
    if (full_mode == 0) wr_full = 1'b0;
    else if (full_mode == 2) wr_full = 1'b1;
    else if (hold > 0) hold--;
    else begin
      wr_full = ($urandom_range(0, 2) == 0);
      hold = $urandom_range(0, 5);
    end
  end

  // Monitor: compare every write against the scoreboard, watch backpressure
  always @(negedge sys_clk) begin
    if (sys_rstn) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got %0h expected none", wr_data);
        end else chk("wr_data", wr_data, exp_q.pop_front());
      end
      chk("grant_onehot", $countones(grant) <= 1, 1);
      if (wr_full) begin
        chk("no_read_when_full", rd0_en | rd1_en, 0);
        if (wr_en) begin
          full_wr++;
          chk("writes_after_full_le2", full_wr <= 2, 1);
        end
      end else full_wr = 0;
    end
  end

  task automatic commit(input int p);
    if (p == 1) ml1.push_back(stage_q.size() - 1);
    else        ml0.push_back(stage_q.size() - 1);
    foreach (stage_q[i]) begin
      if (p == 1) begin q1.push_back(stage_q[i]); mw1.push_back(stage_q[i]); end
      else        begin q0.push_back(stage_q[i]); mw0.push_back(stage_q[i]); end
    end
    stage_q.delete();
  endtask

  task automatic rand_frame(input int p, input int len);
    stage_q.delete();
    for (int i = 0; i < len; i++) stage_q.push_back({1'b1, 8'($urandom)});
    stage_q.push_back({1'b0, 8'($urandom)});
    commit(p);
  endtask

  // Frame-level reference: round-robin over enabled ports holding frames
  task automatic model_flush();
    bit c0, c1, more;
    int p, len;
    logic [8:0] w;
    more = 1'b1;
    while (more) begin
      c0 = port_en[0] && (ml0.size() > 0);
      c1 = port_en[1] && (ml1.size() > 0);
      if (!c0 && !c1) more = 1'b0;
      else begin
        p = (c0 && c1) ? (m_last ? 0 : 1) : (c1 ? 1 : 0);
        len = (p == 1) ? ml1.pop_front() : ml0.pop_front();
        w = '0;
        for (int i = 0; i <= len; i++) begin
          w = (p == 1) ? mw1.pop_front() : mw0.pop_front();
          if (i < len && i < MAXL) exp_q.push_back(w);
        end
        if (len > 0) begin
          if (len > MAXL) begin
            exp_q.push_back(9'h000);
            exp_tc++;
          end else exp_q.push_back(w);
          if (p == 1) exp_fc1++;
          else        exp_fc0++;
          m_last = (p == 1);
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int idle, t;
    idle = 0;
    t = 0;
    while (idle < 4 && t < budget) begin
      @(posedge sys_clk);
      #3;
      t++;
      if (exp_q.size() == 0 && (q0.size() == 0 || !port_en[0]) &&
          (q1.size() == 0 || !port_en[1]) && grant == 2'b00 && !rd0_en && !rd1_en)
        idle++;
      else idle = 0;
    end
    chk({name, "_reached_idle"}, idle >= 4, 1);
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_frame_cnt0"}, frame_cnt0, exp_fc0);
    chk({name, "_frame_cnt1"}, frame_cnt1, exp_fc1);
    chk({name, "_trunc_cnt"}, trunc_cnt, exp_tc);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_wr_en"}, wr_en, 0);
    chk({name, "_wr_data"}, wr_data, 0);
    chk({name, "_grant"}, grant, 0);
    chk({name, "_rd_en"}, {rd1_en, rd0_en}, 0);
    chk({name, "_counters"}, {frame_cnt0, frame_cnt1, trunc_cnt}, 0);
  endtask

  task automatic do_reset(input string name);
    @(posedge sys_clk);
    #2;
    sys_rstn = 1'b0;
    #1;
    chk_reset_outputs(name);
    q0.delete(); q1.delete(); mw0.delete(); mw1.delete();
    ml0.delete(); ml1.delete(); exp_q.delete();
    exp_fc0 = 0; exp_fc1 = 0; exp_tc = 0; m_last = 1'b1;
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rstn = 1'b1;
  endtask

  initial begin
    int rd_c, wr_c, c;

    repeat (2) @(posedge sys_clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge sys_clk);
    #2;
    sys_rstn = 1'b1;

    // Single fixed frame on port0: data path, latency, grant
    port_en = 2'b11;
    @(posedge sys_clk);
    #2;
    stage_q = '{9'h1AA, 9'h1BB, 9'h1CC, 9'h1DD, 9'h000};
    commit(0);
    model_flush();
    rd_c = -1;
    wr_c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (rd0_en && rd_c < 0) rd_c = i;
      if (wr_en && wr_c < 0) begin
        wr_c = i;
        chk("t1_grant_busy", grant, 2'b01);
      end
    end
    chk("t1_rd_to_wr_latency", wr_c - rd_c, 2);
    wait_idle(100, "t1");
    chk("t1_grant_idle", grant, 2'b00);
    chk_counts("t1");

    // Both ports loaded after reset: port0 first, then port1, twice
    do_reset("t2_reset");
    for (int r = 0; r < 2; r++) begin
      @(posedge sys_clk);
      #2;
      rand_frame(0, 3);
      rand_frame(1, 3);
      model_flush();
      wait_idle(200, "t2");
    end
    chk_counts("t2");

    // Truncation at MAX_LEN, exact-MAX boundary, normal frame afterwards
    @(posedge sys_clk);
    #2;
    rand_frame(1, 12);
    rand_frame(1, 4);
    rand_frame(0, MAXL);
    rand_frame(0, MAXL + 1);
    model_flush();
    wait_idle(400, "t3");
    chk_counts("t3");

    // Backpressure held 5 cycles mid-frame
    @(posedge sys_clk);
    #2;
    rand_frame(0, 8);
    model_flush();
    c = 0;
    while (!wr_en && c < 30) begin
      @(negedge sys_clk);
      c++;
    end
    chk("t4_first_write_seen", wr_en, 1);
    full_mode = 2;
    repeat (6) @(posedge sys_clk);
    full_mode = 0;
    wait_idle(200, "t4");

    // Random frames under random backpressure
    full_mode = 1;
    @(posedge sys_clk);
    #2;
    for (int i = 0; i < 12; i++) begin
      rand_frame(0, $urandom_range(0, 12));
      rand_frame(1, $urandom_range(0, 12));
    end
    model_flush();
    wait_idle(5000, "t4_rand");
    full_mode = 0;
    chk_counts("t4");

    // Lone gap word on port1
    @(posedge sys_clk);
    #2;
    stage_q = '{9'h000};
    commit(1);
    model_flush();
    wait_idle(100, "t5");
    chk("t5_port1_consumed", q1.size(), 0);
    chk_counts("t5");

    // Port1 disabled, then reset mid-frame
    port_en = 2'b01;
    @(posedge sys_clk);
    #2;
    rand_frame(0, 5);
    rand_frame(1, 4);
    rand_frame(1, 2);
    rand_frame(0, 3);
    model_flush();
    wait_idle(300, "t6");
    chk("t6_port1_untouched", q1.size(), 8);
    chk_counts("t6");
    @(posedge sys_clk);
    #2;
    rand_frame(0, 6);
    model_flush();
    c = 0;
    while (!wr_en && c < 30) begin
      @(negedge sys_clk);
      c++;
    end
    chk("t6_midframe_write_seen", wr_en, 1);
    do_reset("t6_reset");
    port_en = 2'b11;
    @(posedge sys_clk);
    #2;
    rand_frame(1, 3);
    rand_frame(0, 3);
    model_flush();
    c = 0;
    while (grant == 2'b00 && c < 30) begin
      @(negedge sys_clk);
      c++;
    end
    chk("t6_first_grant_after_reset", grant, 2'b01);
    wait_idle(200, "t6_post");
    chk_counts("t6_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
